// File: rtl/plcp_header_parser.sv
// ---------------------------------------------------------------------------
// plcp_header_parser
//
// Receive-side PLCP framer for the 1 Mbps DBPSK path. Watches the descrambled
// bit stream for 16 SYNC ones followed by the SFD, captures the 48-bit long
// PLCP header (SIGNAL, SERVICE, LENGTH, CRC-16), checks it, and on success
// forwards exactly LENGTH payload bits downstream with a last flag.
//
// Ports
//   clk            single clock, all logic on posedge
//   reset          synchronous, active-low reset
//   data_bit       descrambled bit, qualified by data_valid_bit
//   data_valid_bit one-cycle strobe per bit (back-to-back allowed)
//   restart        abort current frame and return to SEARCH
//   hdr_valid      one-cycle pulse: header passed all checks
//   hdr_signal     SIGNAL field, held until next hdr_valid
//   hdr_service    SERVICE field, held until next hdr_valid
//   hdr_length     LENGTH field in us (= payload bits), held until next hdr_valid
//   hdr_error      one-cycle pulse: header rejected
//   hdr_err_code   01 CRC, 10 bad SIGNAL, 11 bad LENGTH; held until next hdr_error
//   psdu_bit       payload bit in transmission order
//   psdu_valid     one-cycle strobe per payload bit
//   psdu_last      high with psdu_valid on the final payload bit
//   busy           high whenever the parser is not in SEARCH
// ---------------------------------------------------------------------------
module plcp_header_parser #(
  parameter logic [15:0] SFD_PATTERN   = 16'hF3A0,
  parameter logic [7:0]  SIGNAL_RATE   = 8'h0A,
  parameter logic [15:0] MAX_LENGTH_US = 16'd20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_bit,
  input  logic        data_valid_bit,
  input  logic        restart,
  output logic        hdr_valid,
  output logic [7:0]  hdr_signal,
  output logic [7:0]  hdr_service,
  output logic [15:0] hdr_length,
  output logic        hdr_error,
  output logic [1:0]  hdr_err_code,
  output logic        psdu_bit,
  output logic        psdu_valid,
  output logic        psdu_last,
  output logic        busy
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] sh;        // SYNC/SFD window in SEARCH, header fields in HEADER
  logic [5:0]  bit_cnt;   // header bit index 0..47
  logic [15:0] pay_cnt;   // payload bits forwarded so far
  logic [15:0] crc;       // running CRC over header bits 0..31
  logic [15:0] rx_crc;    // received CRC, assembled MSB-first

  // Right shift with the new bit entering at the top: after 32 bits the
  // earliest bit sits in bit 0, so LSB-first fields land in natural order
  // (SIGNAL in [7:0], SERVICE in [15:8], LENGTH in [31:16]).
  logic [31:0] sh_shifted;
  logic        sync_match;
  logic        crc_fb;
  logic [15:0] crc_next;
  logic [15:0] rx_crc_next;
  logic [15:0] pay_cnt_inc;
  logic [1:0]  chk_code;

  assign sh_shifted  = {data_bit, sh[31:1]};
  assign sync_match  = (sh_shifted == {SFD_PATTERN, 16'hFFFF});
  assign crc_fb      = data_bit ^ crc[15];
  assign crc_next    = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  // The 48th bit is folded in combinationally so the decision is made on
  // the strobe of that bit and reported on the following cycle.
  assign rx_crc_next = {rx_crc[14:0], data_bit};
  assign pay_cnt_inc = pay_cnt + 16'd1;

  // Header check, highest priority first: CRC, then SIGNAL, then LENGTH.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can
    // leave it unassigned and infer a latch.
    chk_code = 2'b00;
    if (rx_crc_next != ~crc) begin
      chk_code = 2'b01;
    end else if (sh[7:0] != SIGNAL_RATE) begin
      chk_code = 2'b10;
    end else if ((sh[31:16] == 16'd0) || (sh[31:16] > MAX_LENGTH_US)) begin
      chk_code = 2'b11;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= SEARCH;
      sh           <= '0;
      bit_cnt      <= '0;
      pay_cnt      <= '0;
      crc          <= '0;
      rx_crc       <= '0;
      hdr_valid    <= 1'b0;
      hdr_signal   <= '0;
      hdr_service  <= '0;
      hdr_length   <= '0;
      hdr_error    <= 1'b0;
      hdr_err_code <= '0;
      psdu_bit     <= 1'b0;
      psdu_valid   <= 1'b0;
      psdu_last    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Pulses default low; they are raised only by the branch below.
      hdr_valid  <= 1'b0;
      hdr_error  <= 1'b0;
      psdu_valid <= 1'b0;
      psdu_last  <= 1'b0;

      if (restart) begin
        // The bit presented alongside restart is dropped.
        state   <= SEARCH;
        sh      <= '0;
        bit_cnt <= '0;
        pay_cnt <= '0;
        busy    <= 1'b0;
      end else if (data_valid_bit) begin
        case (state)
          SEARCH: begin
            sh <= sh_shifted;
            if (sync_match) begin
              state   <= HEADER;
              busy    <= 1'b1;
              bit_cnt <= '0;
              crc     <= 16'hFFFF;
            end
          end

          HEADER: begin
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt < 6'd32) begin
              sh  <= sh_shifted;
              crc <= crc_next;
            end else begin
              rx_crc <= rx_crc_next;
            end
            if (bit_cnt == 6'd47) begin
              bit_cnt <= '0;
              if (chk_code == 2'b00) begin
                hdr_valid   <= 1'b1;
                hdr_signal  <= sh[7:0];
                hdr_service <= sh[15:8];
                hdr_length  <= sh[31:16];
                pay_cnt     <= '0;
                state       <= PAYLOAD;
              end else begin
                hdr_error    <= 1'b1;
                hdr_err_code <= chk_code;
                state        <= SEARCH;
                busy         <= 1'b0;
                sh           <= '0;
              end
            end
          end

          PAYLOAD: begin
            psdu_valid <= 1'b1;
            psdu_bit   <= data_bit;
            pay_cnt    <= pay_cnt_inc;
            if (pay_cnt_inc == hdr_length) begin
              psdu_last <= 1'b1;
              state     <= SEARCH;
              busy      <= 1'b0;
              sh        <= '0;
              pay_cnt   <= '0;
            end
          end

          default: begin
            state <= SEARCH;
            busy  <= 1'b0;
            sh    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plcp_header_parser.sv
// ---------------------------------------------------------------------------
// tb_plcp_header_parser
//
// Frame-level bench: each frame is built from its fields, the expected
// decoder response (header accept/reject, payload bits with last flag) is
// derived from the framing rules and queued, and an independent monitor
// compares every output pulse against the head of that queue.
// ---------------------------------------------------------------------------
module tb_plcp_header_parser;

  localparam logic [15:0] SFD = 16'hF3A0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data_bit = 1'b0;
  logic        data_valid_bit = 1'b0;
  logic        restart = 1'b0;
  logic        hdr_valid;
  logic [7:0]  hdr_signal;
  logic [7:0]  hdr_service;
  logic [15:0] hdr_length;
  logic        hdr_error;
  logic [1:0]  hdr_err_code;
  logic        psdu_bit;
  logic        psdu_valid;
  logic        psdu_last;
  logic        busy;

  plcp_header_parser dut (
    .clk            (clk),
    .reset          (reset),
    .data_bit       (data_bit),
    .data_valid_bit (data_valid_bit),
    .restart        (restart),
    .hdr_valid      (hdr_valid),
    .hdr_signal     (hdr_signal),
    .hdr_service    (hdr_service),
    .hdr_length     (hdr_length),
    .hdr_error      (hdr_error),
    .hdr_err_code   (hdr_err_code),
    .psdu_bit       (psdu_bit),
    .psdu_valid     (psdu_valid),
    .psdu_last      (psdu_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_NONE, EV_HDR, EV_ERR, EV_PSDU} ev_t;

  typedef struct {
    ev_t         kind;
    logic [7:0]  sig;
    logic [7:0]  svc;
    logic [15:0] len;
    logic [1:0]  code;
    logic        b;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t blank_exp();
    exp_t e;
    e.kind = EV_NONE;
    e.sig  = '0;
    e.svc  = '0;
    e.len  = '0;
    e.code = '0;
    e.b    = 1'b0;
    e.last = 1'b0;
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e = blank_exp();
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // ---------------- reference model ----------------
  // hv[i] is header bit i in transmission order.
  function automatic logic [15:0] ref_crc(input logic [31:0] bits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = bits[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [1:0] ref_code(input logic [47:0] hv);
    logic [15:0] rx;
    logic [15:0] len;
    for (int k = 0; k < 16; k++) rx[15-k] = hv[32+k];
    len = hv[31:16];
    if (rx != ~ref_crc(hv[31:0])) return 2'b01;
    if (hv[7:0] != 8'h0A) return 2'b10;
    if (len == 16'd0 || len > 16'd20000) return 2'b11;
    return 2'b00;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (hdr_valid || hdr_error)
      check("hdr_exclusive", {63'd0, hdr_valid & hdr_error}, 64'd0);
    if (hdr_valid) begin
      e = pop_exp();
      check("hdr_valid_kind", EV_HDR, e.kind);
      if (e.kind == EV_HDR) begin
        check("hdr_signal", hdr_signal, e.sig);
        check("hdr_service", hdr_service, e.svc);
        check("hdr_length", hdr_length, e.len);
      end
    end
    if (hdr_error) begin
      e = pop_exp();
      check("hdr_error_kind", EV_ERR, e.kind);
      if (e.kind == EV_ERR) check("hdr_err_code", hdr_err_code, e.code);
    end
    if (psdu_valid) begin
      e = pop_exp();
      check("psdu_kind", EV_PSDU, e.kind);
      if (e.kind == EV_PSDU) begin
        check("psdu_bit", psdu_bit, e.b);
        check("psdu_last", psdu_last, e.last);
      end
    end else if (psdu_last) begin
      check("psdu_last_without_valid", psdu_last, 1'b0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected run completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rgap(input int gap_max);
    return int'($urandom_range(gap_max, 0));
  endfunction

  task automatic send_bit(input logic b, input int gap, input logic rs);
    data_valid_bit = 1'b0;
    repeat (gap) tick();
    data_bit       = b;
    data_valid_bit = 1'b1;
    restart        = rs;
    tick();
    data_valid_bit = 1'b0;
    restart        = 1'b0;
  endtask

  // Filler never holds more than 7 ones in a row, so it cannot form SYNC.
  task automatic send_filler(input int n, input int gap_max);
    for (int i = 0; i < n; i++)
      send_bit((i % 8 == 7) ? 1'b0 : 1'($urandom), rgap(gap_max), 1'b0);
  endtask

  // restart_at >= 0: send that many payload bits, then one more with restart.
  task automatic send_frame(input int ones, input logic [7:0] sig, input logic [7:0] svc,
                            input logic [15:0] len, input int flip, input int gap_max,
                            input int restart_at);
    logic [47:0] hv;
    logic [15:0] fcs;
    logic [1:0]  code;
    logic        pay[$];
    exp_t        e;
    int          n_pay;
    hv       = '0;
    hv[31:0] = {len, svc, sig};
    fcs      = ~ref_crc(hv[31:0]);
    for (int k = 0; k < 16; k++) hv[32+k] = fcs[15-k];
    if (flip >= 0) hv[flip] = ~hv[flip];

    send_bit(1'b0, rgap(gap_max), 1'b0);
    repeat (ones) send_bit(1'b1, rgap(gap_max), 1'b0);
    for (int i = 0; i < 16; i++) send_bit(SFD[i], rgap(gap_max), 1'b0);
    check("busy_after_sfd", busy, (ones >= 16));
    if (ones < 16) return;

    code = ref_code(hv);
    e = blank_exp();
    if (code == 2'b00) begin
      e.kind = EV_HDR;
      e.sig  = hv[7:0];
      e.svc  = hv[15:8];
      e.len  = hv[31:16];
    end else begin
      e.kind = EV_ERR;
      e.code = code;
    end
    sb.push_back(e);

    n_pay = 0;
    if (code == 2'b00) begin
      n_pay = (restart_at >= 0) ? restart_at : int'(len);
      for (int i = 0; i < n_pay; i++) begin
        pay.push_back(1'($urandom));
        e      = blank_exp();
        e.kind = EV_PSDU;
        e.b    = pay[i];
        e.last = (restart_at < 0) && (i == n_pay - 1);
        sb.push_back(e);
      end
    end

    for (int i = 0; i < 48; i++) send_bit(hv[i], rgap(gap_max), 1'b0);
    for (int i = 0; i < n_pay; i++) send_bit(pay[i], rgap(gap_max), 1'b0);
    if (code == 2'b00 && restart_at >= 0) send_bit(1'($urandom), rgap(gap_max), 1'b1);
    check("busy_after_frame", busy, 1'b0);
  endtask

  function automatic logic [39:0] all_outputs();
    return {hdr_valid, hdr_signal, hdr_service, hdr_length, hdr_error,
            hdr_err_code, psdu_bit, psdu_valid, psdu_last, busy};
  endfunction

  initial begin
    int          ones;
    int          flip;
    int          gmax;
    int          r;
    logic [7:0]  sig;
    logic [15:0] len;

    reset = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_outputs(), 40'd0);
    reset = 1'b1;
    tick();

    // 1: nominal frame, 16-bit payload
    send_frame(16, 8'h0A, 8'h00, 16'd16, -1, 1, -1);
    check("t1_hdr_length_held", hdr_length, 16'd16);
    send_filler(10, 1);

    // 2: CRC bit 40 flipped, then a good frame
    send_frame(16, 8'h0A, 8'h00, 16'd16, 40, 1, -1);
    check("t2_err_code", hdr_err_code, 2'b01);
    send_frame(16, 8'h0A, 8'h00, 16'd16, -1, 1, -1);
    check("t2_err_code_held", hdr_err_code, 2'b01);

    // 3: bad SIGNAL, zero LENGTH, oversized LENGTH, boundary one over max
    send_frame(16, 8'h14, 8'h00, 16'd16, -1, 1, -1);
    check("t3_bad_signal", hdr_err_code, 2'b10);
    send_frame(16, 8'h0A, 8'h00, 16'd0, -1, 1, -1);
    check("t3_len_zero", hdr_err_code, 2'b11);
    send_frame(16, 8'h0A, 8'h00, 16'hFFFF, -1, 1, -1);
    check("t3_len_ffff", hdr_err_code, 2'b11);
    send_frame(16, 8'h0A, 8'h5A, 16'd20001, -1, 0, -1);
    check("t3_len_20001", hdr_err_code, 2'b11);

    // 4: only 15 SYNC ones -> no lock; noise; then a good frame
    send_frame(15, 8'h0A, 8'h00, 16'd16, -1, 1, -1);
    send_filler(40, 1);
    check("t4_busy_after_noise", busy, 1'b0);
    send_frame(16, 8'h0A, 8'h33, 16'd24, -1, 1, -1);

    // 5: restart on payload bit 8, then an immediate good frame
    send_frame(16, 8'h0A, 8'h00, 16'd16, -1, 1, 7);
    send_frame(16, 8'h0A, 8'h00, 16'd16, -1, 1, -1);

    // 6: back-to-back strobes, then reset mid-header
    send_frame(16, 8'h0A, 8'h00, 16'd16, -1, 0, -1);
    check("t6_hdr_length", hdr_length, 16'd16);
    send_bit(1'b0, 0, 1'b0);
    repeat (16) send_bit(1'b1, 0, 1'b0);
    for (int i = 0; i < 16; i++) send_bit(SFD[i], 0, 1'b0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom), 0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    check("t6_reset_outputs", all_outputs(), 40'd0);
    reset = 1'b1;
    tick();
    send_frame(16, 8'h0A, 8'h00, 16'd16, -1, 0, -1);

    // Largest legal LENGTH
    send_frame(16, 8'h0A, 8'hC3, 16'd20000, -1, 0, -1);
    send_filler(5, 0);

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      ones = 16 + int'($urandom_range(4, 0));
      sig  = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h0A;
      r    = int'($urandom_range(9, 0));
      if (r == 0)      len = 16'd0;
      else if (r == 1) len = 16'd20001 + 16'($urandom_range(500, 0));
      else             len = 16'($urandom_range(40, 1));
      flip = ($urandom_range(4, 0) == 0) ? int'($urandom_range(47, 0)) : -1;
      gmax = int'($urandom_range(2, 0));
      send_frame(ones, sig, 8'($urandom), len, flip, gmax, -1);
      send_filler(int'($urandom_range(12, 0)), gmax);
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
